// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, requests words from instruction memory
// over a req/valid handshake, selects the next PC, and drives the IF/ID register.
// A one-entry skip buffer keeps a response that lands during a decode stall, and
// in-flight fetches are drained and discarded when the PC is redirected.
module fetch_stage #(
    parameter int unsigned                PC_WIDTH    = 16,
    parameter int unsigned                INSTR_WIDTH = 16,
    parameter logic [PC_WIDTH-1:0]        RESET_PC    = '0,
    parameter logic [INSTR_WIDTH-1:0]     NOP         = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stall,
    input  logic [1:0]             pc_src,
    input  logic [PC_WIDTH-1:0]    branch_target,
    input  logic [PC_WIDTH-1:0]    jump_target,
    input  logic [PC_WIDTH-1:0]    return_addr,
    output logic                   imem_req,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic                   imem_valid,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    output logic [INSTR_WIDTH-1:0] instruction,
    output logic [PC_WIDTH-1:0]    npc,
    output logic [PC_WIDTH-1:0]    pc_out,
    output logic                   if_valid
);

    typedef enum logic [1:0] {
        ST_REQ   = 2'd0,  // request outstanding at pc
        ST_DRAIN = 2'd1,  // squashed request outstanding at drain_addr
        ST_BUF   = 2'd2   // response parked in skip buffer, no request
    } state_t;

    state_t                 state, state_n;
    logic [PC_WIDTH-1:0]    pc, pc_n;
    logic [PC_WIDTH-1:0]    drain_addr, drain_addr_n;
    logic [INSTR_WIDTH-1:0] buf_instr, buf_instr_n;
    logic [PC_WIDTH-1:0]    buf_pc, buf_pc_n;
    logic [INSTR_WIDTH-1:0] instr_n;
    logic [PC_WIDTH-1:0]    npc_n, pc_out_n;
    logic                   if_valid_n;

    logic [PC_WIDTH-1:0]    redirect_pc;
    logic [PC_WIDTH-1:0]    pc_inc;
    logic [PC_WIDTH-1:0]    buf_pc_inc;

    assign pc_inc     = pc + PC_WIDTH'(1);
    assign buf_pc_inc = buf_pc + PC_WIDTH'(1);

    // Memory request: active unless a response is parked; a squashed request
    // keeps its original address until its response arrives.
    assign imem_req  = (state != ST_BUF);
    assign imem_addr = (state == ST_DRAIN) ? drain_addr : pc;

    // Redirect target selection.
    always_comb begin
        redirect_pc = pc;
        case (pc_src)
            2'b01:   redirect_pc = branch_target;
            2'b10:   redirect_pc = jump_target;
            2'b11:   redirect_pc = return_addr;
            default: redirect_pc = pc;
        endcase
    end

    // Next-state and next-register logic: redirect > stall > normal.
    always_comb begin
        state_n      = state;
        pc_n         = pc;
        drain_addr_n = drain_addr;
        buf_instr_n  = buf_instr;
        buf_pc_n     = buf_pc;
        instr_n      = instruction;
        npc_n        = npc;
        pc_out_n     = pc_out;
        if_valid_n   = if_valid;

        if (pc_src != 2'b00) begin
            pc_n        = redirect_pc;
            instr_n     = NOP;
            if_valid_n  = 1'b0;
            buf_instr_n = '0;
            buf_pc_n    = '0;
            case (state)
                ST_REQ: begin
                    if (!imem_valid) begin
                        state_n      = ST_DRAIN;
                        drain_addr_n = pc;
                    end
                end
                // A response landing here retires the squashed request, so
                // nothing remains to drain.
                ST_DRAIN: state_n = imem_valid ? ST_REQ : ST_DRAIN;
                ST_BUF:   state_n = ST_REQ;
                default:  state_n = ST_REQ;
            endcase
        end else begin
            case (state)
                ST_REQ: begin
                    if (imem_valid) begin
                        pc_n = pc_inc;
                        if (stall) begin
                            buf_instr_n = imem_rdata;
                            buf_pc_n    = pc;
                            state_n     = ST_BUF;
                        end else begin
                            instr_n    = imem_rdata;
                            pc_out_n   = pc;
                            npc_n      = pc_inc;
                            if_valid_n = 1'b1;
                        end
                    end else if (!stall) begin
                        instr_n    = NOP;
                        if_valid_n = 1'b0;
                    end
                end
                ST_DRAIN: begin
                    if (imem_valid) begin
                        state_n = ST_REQ;
                    end
                    if (!stall) begin
                        instr_n    = NOP;
                        if_valid_n = 1'b0;
                    end
                end
                ST_BUF: begin
                    if (!stall) begin
                        instr_n     = buf_instr;
                        pc_out_n    = buf_pc;
                        npc_n       = buf_pc_inc;
                        if_valid_n  = 1'b1;
                        buf_instr_n = '0;
                        buf_pc_n    = '0;
                        state_n     = ST_REQ;
                    end
                end
                default: state_n = ST_REQ;
            endcase
        end
    end

    // State, PC, skip buffer and IF/ID registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_REQ;
            pc          <= RESET_PC;
            drain_addr  <= '0;
            buf_instr   <= '0;
            buf_pc      <= '0;
            instruction <= NOP;
            npc         <= '0;
            pc_out      <= '0;
            if_valid    <= 1'b0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            drain_addr  <= drain_addr_n;
            buf_instr   <= buf_instr_n;
            buf_pc      <= buf_pc_n;
            instruction <= instr_n;
            npc         <= npc_n;
            pc_out      <= pc_out_n;
            if_valid    <= if_valid_n;
        end
    end

endmodule
